// File: rtl/ct_ct_mod_add.sv
// ct_ct_mod_add: registered ciphertext + ciphertext adder, modulo QP.
//
// Each ciphertext holds two N-slot coefficient vectors (A, B). Every slot is
// reduced by its own add/compare/subtract lane, so there are 2N lanes working
// in parallel. The result is registered, which gives a latency of one cycle
// and a throughput of one pair per cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (clears out_valid and out_ct)
//   in_valid   operand pair on in_ct1/in_ct2 is to be accepted this edge
//   in_ct1     first ciphertext  (CT_t: A[0..N-1], B[0..N-1], W bits each)
//   in_ct2     second ciphertext (same layout)
//   out_valid  registered copy of in_valid
//   out_ct     sum ciphertext; holds its value when in_valid is low

package ct_types_pkg;
    localparam int N_SLOTS_L = 8;
    localparam int W_BITS_L  = 16;

    typedef logic [N_SLOTS_L-1:0][W_BITS_L-1:0] vec_t;

    typedef struct packed {
        vec_t A;
        vec_t B;
    } CT_t;
endpackage

// One slot: a single conditional subtract. This is exact when both operands
// are in [0, QP-1]. Operands outside that range get the same treatment and
// are neither reduced further nor flagged.
module ct_mod_add_lane #(
    parameter int          W  = 16,
    parameter int unsigned QP = 16'd7710
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    localparam logic [W:0] QP_X = (W+1)'(QP);

    // The sum is kept W+1 bits wide so that a carry out of bit W-1 still
    // takes part in the compare against QP.
    logic [W:0] s;
    logic       ge;

    assign s   = {1'b0, a} + {1'b0, b};
    assign ge  = (s >= QP_X);
    assign sum = W'(ge ? (s - QP_X) : s);
endmodule

module ct_ct_mod_add
    import ct_types_pkg::*;
#(
    // N and W size the lane array. They must match the CT_t layout in
    // ct_types_pkg.
    parameter int          N  = N_SLOTS_L,
    parameter int          W  = W_BITS_L,
    parameter int unsigned QP = 16'd7710
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  CT_t  in_ct1,
    input  CT_t  in_ct2,
    output logic out_valid,
    output CT_t  out_ct
);
    logic [N-1:0][W-1:0] sum_a;
    logic [N-1:0][W-1:0] sum_b;
    CT_t                 sum_ct;

    for (genvar i = 0; i < N; i++) begin : g_slot
        ct_mod_add_lane #(.W(W), .QP(QP)) u_lane_a (
            .a   (in_ct1.A[i]),
            .b   (in_ct2.A[i]),
            .sum (sum_a[i])
        );
        ct_mod_add_lane #(.W(W), .QP(QP)) u_lane_b (
            .a   (in_ct1.B[i]),
            .b   (in_ct2.B[i]),
            .sum (sum_b[i])
        );
    end

    always_comb begin
        sum_ct   = '0;
        sum_ct.A = sum_a;
        sum_ct.B = sum_b;
    end

    // Reset takes priority and discards any pair presented in the same cycle.
    // The data register loads only on accepted pairs, so the last result
    // stays visible while out_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ct    <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_ct <= sum_ct;
            end
        end
    end
endmodule

// File: tb/tb_ct_ct_mod_add.sv
module tb_ct_ct_mod_add;
    import ct_types_pkg::*;

    localparam int N  = N_SLOTS_L;
    localparam int W  = W_BITS_L;
    localparam int QP = 7710;

    typedef struct {
        bit  valid;
        CT_t ct;
    } exp_t;

    logic clk;
    logic rst;
    logic in_valid;
    CT_t  in_ct1;
    CT_t  in_ct2;
    logic out_valid;
    CT_t  out_ct;

    exp_t exp_q[$];
    CT_t  m_ct;          // model of what out_ct should be holding
    int   n_checks;
    int   n_pass;

    ct_ct_mod_add #(.N(N), .W(W), .QP(QP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ct1    (in_ct1),
        .in_ct2    (in_ct2),
        .out_valid (out_valid),
        .out_ct    (out_ct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the plain modular sum of each coefficient.
    function automatic CT_t ref_add(input CT_t x, input CT_t y);
        CT_t r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r.A[i] = W'((int'(x.A[i]) + int'(y.A[i])) % QP);
            r.B[i] = W'((int'(x.B[i]) + int'(y.B[i])) % QP);
        end
        return r;
    endfunction

    function automatic CT_t rand_ct();
        CT_t r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r.A[i] = W'($urandom_range(QP - 1));
            r.B[i] = W'($urandom_range(QP - 1));
        end
        return r;
    endfunction

    // Present the inputs for one cycle. At the edge, record what the outputs
    // should show after that edge.
    task automatic step(input bit r, input bit v, input CT_t a, input CT_t b);
        exp_t e;
        rst      = r;
        in_valid = v;
        in_ct1   = a;
        in_ct2   = b;
        @(posedge clk);
        if (r)      m_ct = '0;
        else if (v) m_ct = ref_add(a, b);
        e.valid = !r && v;
        e.ct    = m_ct;
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: compares every recorded cycle at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (out_valid === e.valid) n_pass++;
                else $display("FAIL out_valid: got %b want %b at %0t", out_valid, e.valid, $time);
                n_checks++;
                if (out_ct === e.ct) n_pass++;
                else $display("FAIL out_ct: got %h want %h at %0t", out_ct, e.ct, $time);
            end else if (out_valid === 1'b1) begin
                n_checks++;
                $display("FAIL spurious out_valid: got 1 want 0 at %0t", $time);
            end
        end
    end

    initial begin
        CT_t a, b, z;
        n_checks = 0;
        n_pass   = 0;
        m_ct     = '0;
        z        = '0;

        // reset state, then reset asserted with nonzero valid data
        step(1, 0, z, z);
        step(1, 1, rand_ct(), rand_ct());

        // fixed vector
        a = '0; b = '0;
        a.A = {16'd973, 16'd6931, 16'd6215, 16'd7215, 16'd3279, 16'd6311, 16'd4717, 16'd1429};
        a.B = {16'd4640, 16'd5576, 16'd964, 16'd5909, 16'd7529, 16'd1094, 16'd4381, 16'd7531};
        b.A = {16'd3013, 16'd152, 16'd4, 16'd2873, 16'd5762, 16'd951, 16'd592, 16'd1081};
        b.B = {16'd7656, 16'd1531, 16'd6280, 16'd2056, 16'd6187, 16'd6039, 16'd3917, 16'd1577};
        step(0, 1, a, b);

        // boundaries: 7709+0, 7709+1, 3855+3855, 7709+7709 in A and B slots
        a = '0; b = '0;
        a.A[0] = 16'd7709; b.A[0] = 16'd0;
        a.A[1] = 16'd7709; b.A[1] = 16'd1;
        a.A[2] = 16'd3855; b.A[2] = 16'd3855;
        a.A[3] = 16'd7709; b.A[3] = 16'd7709;
        a.B[4] = 16'd7709; b.B[4] = 16'd7709;
        a.B[5] = 16'd3855; b.B[5] = 16'd3855;
        a.B[6] = 16'd7709; b.B[6] = 16'd1;
        a.B[7] = 16'd7709; b.B[7] = 16'd0;
        step(0, 1, a, b);

        // slot isolation
        a = '0; b = '0;
        a.A[5] = 16'd4; b.A[5] = 16'd4;
        step(0, 1, a, b);

        // streaming: 4 back-to-back random pairs
        for (int i = 0; i < 4; i++) step(0, 1, rand_ct(), rand_ct());

        // hold: 3 idle cycles with changing data
        for (int i = 0; i < 3; i++) step(0, 0, rand_ct(), rand_ct());

        // reset mid-stream, then resume immediately
        step(0, 1, rand_ct(), rand_ct());
        step(1, 1, rand_ct(), rand_ct());
        step(0, 1, rand_ct(), rand_ct());
        step(0, 1, rand_ct(), rand_ct());

        // random mix of valid and idle cycles
        for (int i = 0; i < 40; i++)
            step(0, ($urandom_range(3) != 0), rand_ct(), rand_ct());

        step(0, 0, z, z);
        repeat (3) @(negedge clk);

        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
